alu_muldiv_ctrl: RTL and testbench

ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

---
 rtl/alu_muldiv_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_ctrl.sv
// ALU operation decoder plus iterative RV32M multiply/divide sequencer.
// Radix-2 shift-add multiply and restoring divide, XLEN cycles each.
`timescale 1ns/1ps
module alu_muldiv_ctrl #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      aluop,
  input  logic [6:0]      func7,
  input  logic [2:0]      func3,
  input  logic            add4,
  input  logic            start,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [OPW-1:0]  operation,
  output logic            stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_PC4    = 5'd11;
  localparam logic [4:0] OP_BEQ    = 5'd12;
  localparam logic [4:0] OP_BNE    = 5'd13;
  localparam logic [4:0] OP_BLT    = 5'd14;
  localparam logic [4:0] OP_BGE    = 5'd15;
  localparam logic [4:0] OP_BLTU   = 5'd16;
  localparam logic [4:0] OP_BGEU   = 5'd17;
  localparam logic [4:0] OP_MULDIV = 5'd18;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  function automatic logic [4:0] f3op(
    input logic [2:0] f
  );
    logic [4:0] o;
    o = OP_ADD;
    unique case (f)
      3'b001:  o = OP_SLL;
      3'b010:  o = OP_SLT;
      3'b011:  o = OP_SLTU;
      3'b100:  o = OP_XOR;
      3'b101:  o = OP_SRL;
      3'b110:  o = OP_OR;
      3'b111:  o = OP_AND;
      default: o = OP_ADD;
    endcase
    return o;
  endfunction

  // Operand signedness: rs1 side and rs2 side
  function automatic logic sgn1(
    input logic [2:0] f
  );
    return f[2] ? ~f[0] : (f[1:0] != 2'b11);
  endfunction

  function automatic logic sgn2(
    input logic [2:0] f
  );
    return f[2] ? ~f[0] : ~f[1];
  endfunction

  function automatic logic [XLEN-1:0] mag(
    input logic [XLEN-1:0] x,
    input logic            s
  );
    return (s && x[XLEN-1]) ? -x : x;
  endfunction

  state_t              r_state;
  state_t              w_nxt;
  logic [4:0]          w_op;
  logic                w_mop;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic [1:0]          r_f3;
  logic                r_nq;
  logic                r_nr;
  logic [CW-1:0]       r_cnt;
  logic                w_last;
  logic                w_s1;
  logic                w_s2;
  logic [XLEN-1:0]     w_m1;
  logic [XLEN-1:0]     w_m2;
  logic                w_dz;
  logic                w_ovf;
  logic                w_short;
  logic [XLEN-1:0]     w_spec;
  logic [XLEN:0]       w_msum;
  logic [2*XLEN-1:0]   w_mul_nxt;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN:0]       w_dsh;
  logic [XLEN:0]       w_ddiff;
  logic [2*XLEN-1:0]   w_div_nxt;
  logic [XLEN-1:0]     w_dq;
  logic [XLEN-1:0]     w_dr;

  always_comb begin
    w_op = OP_ADD;
    unique case (1'b1)
      aluop == 5'd1: begin
        unique case (func3)
          3'b000:  w_op = OP_BEQ;
          3'b001:  w_op = OP_BNE;
          3'b100:  w_op = OP_BLT;
          3'b101:  w_op = OP_BGE;
          3'b110:  w_op = OP_BLTU;
          3'b111:  w_op = OP_BGEU;
          default: w_op = OP_ADD;
        endcase
      end
      aluop == 5'd2: begin
        if (func7 == F7_MD)
          w_op = OP_MULDIV;
        else if (func7 == F7_ZERO)
          w_op = f3op(func3);
        else if (func7 == F7_ALT && func3 == 3'b000)
          w_op = OP_SUB;
        else if (func7 == F7_ALT && func3 == 3'b101)
          w_op = OP_SRA;
      end
      aluop == 5'd3: begin
        if (func3 == 3'b001)
          w_op = (func7 == F7_ZERO) ? OP_SLL : OP_ADD;
        else if (func3 == 3'b101)
          w_op = (func7 == F7_ZERO) ? OP_SRL :
                 (func7 == F7_ALT)  ? OP_SRA : OP_ADD;
        else
          w_op = f3op(func3);
      end
      aluop == 5'd4: w_op = OP_PASSB;
      aluop == 5'd5: w_op = add4 ? OP_PC4 : OP_ADD;
      default:       w_op = OP_ADD;
    endcase
  end

  assign operation = OPW'(w_op);
  assign w_mop     = (w_op == OP_MULDIV) && start;

  always_comb begin
    w_s1    = sgn1(func3);
    w_s2    = sgn2(func3);
    w_m1    = mag(rs1, w_s1);
    w_m2    = mag(rs2, w_s2);
    w_dz    = (rs2 == '0);
    w_ovf   = w_s1 && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
    w_short = func3[2] && (w_dz || w_ovf);
    if (w_dz)
      w_spec = func3[1] ? rs1 : '1;
    else
      w_spec = func3[1] ? '0 : rs1;
  end

  // Multiply step: add multiplicand into high half when LSB set, then shift
  always_comb begin
    w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
    if (r_acc[0])
      w_mul_nxt = {w_msum, r_acc[XLEN-1:1]};
    else
      w_mul_nxt = {1'b0, r_acc[2*XLEN-1:1]};
    w_prod = r_nq ? -w_mul_nxt : w_mul_nxt;
  end

  // Divide step: remainder in high half, dividend/quotient in low half
  always_comb begin
    w_dsh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_ddiff = w_dsh - {1'b0, r_opnd};
    if (!w_ddiff[XLEN])
      w_div_nxt = {w_ddiff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    else
      w_div_nxt = {w_dsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    w_dq = r_nq ? -w_div_nxt[XLEN-1:0] : w_div_nxt[XLEN-1:0];
    w_dr = r_nr ? -w_div_nxt[2*XLEN-1:XLEN] : w_div_nxt[2*XLEN-1:XLEN];
  end

  assign w_last = (r_cnt == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_mop)
          w_nxt = w_short  ? S_DONE :
                  func3[2] ? S_DIV  : S_MUL;
      end
      S_MUL:   if (w_last) w_nxt = S_DONE;
      S_DIV:   if (w_last) w_nxt = S_DONE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    md_done = (r_state == S_DONE);
    stall   = w_mop && (r_state != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_opnd    <= '0;
      r_f3      <= '0;
      r_nq      <= 1'b0;
      r_nr      <= 1'b0;
      r_cnt     <= '0;
      md_result <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mop) begin
            r_f3   <= func3[1:0];
            r_nq   <= (w_s1 & rs1[XLEN-1]) ^ (w_s2 & rs2[XLEN-1]);
            r_nr   <= w_s1 & rs1[XLEN-1];
            r_cnt  <= '0;
            r_acc  <= {{XLEN{1'b0}}, func3[2] ? w_m1 : w_m2};
            r_opnd <= func3[2] ? w_m2 : w_m1;
            if (w_short)
              md_result <= w_spec;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last)
            md_result <= (r_f3 == 2'b00) ? w_prod[XLEN-1:0] :
                                           w_prod[2*XLEN-1:XLEN];
        end
        S_DIV: begin
          r_acc <= w_div_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last)
            md_result <= r_f3[1] ? w_dr : w_dq;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Scoreboard bench for alu_muldiv_ctrl at XLEN=32.
// Directed vectors; a negedge monitor pops expected results on md_done.
`timescale 1ns/1ps
module tb_alu_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  aluop;
  logic [6:0]  func7;
  logic [2:0]  func3;
  logic        add4;
  logic        start;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  operation;
  logic        stall;
  logic        md_done;
  logic [31:0] md_result;

  alu_muldiv_ctrl #(.XLEN(32), .OPW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .aluop     (aluop),
    .func7     (func7),
    .func3     (func3),
    .add4      (add4),
    .start     (start),
    .rs1       (rs1),
    .rs2       (rs2),
    .operation (operation),
    .stall     (stall),
    .md_done   (md_done),
    .md_result (md_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (md_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: md_done=1 at cycle %0d expected 0",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.nm, "_res"}, md_result, e.res);
        check({e.nm, "_cyc"}, cyc, e.at);
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    aluop = 5'd0; func7 = 7'd0; func3 = 3'd0;
    add4 = 1'b0; start = 1'b0; rs1 = '0; rs2 = '0;
  endtask

  task automatic chk_op(input string nm, input logic [4:0] ao,
                        input logic [6:0] f7, input logic [2:0] f3,
                        input logic a4, input logic st,
                        input logic [4:0] exp);
    @(posedge clk); #1;
    aluop = ao; func7 = f7; func3 = f3; add4 = a4; start = st;
    rs1 = 32'h1234; rs2 = 32'h5678;
    @(negedge clk);
    check({nm, "_op"}, {27'd0, operation}, {27'd0, exp});
    check({nm, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ex,
                       input int lat, input string nm);
    @(posedge clk); #1;
    aluop = 5'd2; func7 = 7'b0000001; func3 = f3; add4 = 1'b0;
    rs1 = a; rs2 = b; start = 1'b1;
    sb.push_back('{ex, cyc + lat, nm});
  endtask

  task automatic wait_done(input string nm, input int limit,
                           input bit scramble);
    int bad;
    bit got;
    bad = 0;
    got = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (md_done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (stall !== 1'b1) bad++;
      if (scramble && k == 3) begin
        rs1 = $urandom;
        rs2 = $urandom;
      end
    end
    check({nm, "_stall_held"}, bad, 0);
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: md_done=0 after %0d cycles expected 1",
               nm, limit);
    end else begin
      check({nm, "_stall_done"}, {31'd0, stall}, 32'd0);
    end
  endtask

  task automatic mop(input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ex,
                     input int lat, input string nm);
    issue(f3, a, b, ex, lat, nm);
    wait_done(nm, lat + 5, 1'b0);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1;
    aluop = 5'd0; func7 = 7'd0; func3 = 3'd0;
    add4 = 1'b0; start = 1'b0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", {31'd0, md_done}, 32'd0);
    check("rst_result", md_result, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    chk_op("sub",     5'd2, 7'b0100000, 3'b000, 1'b0, 1'b1, 5'd1);
    chk_op("bltu",    5'd1, 7'd0,       3'b110, 1'b0, 1'b1, 5'd16);
    chk_op("pc4",     5'd5, 7'd0,       3'b000, 1'b1, 1'b1, 5'd11);
    chk_op("jmp_add", 5'd5, 7'd0,       3'b000, 1'b0, 1'b1, 5'd0);
    chk_op("load",    5'd0, 7'd0,       3'b010, 1'b0, 1'b1, 5'd0);
    chk_op("lui",     5'd4, 7'd0,       3'b000, 1'b0, 1'b1, 5'd10);
    chk_op("sra",     5'd2, 7'b0100000, 3'b101, 1'b0, 1'b1, 5'd7);
    chk_op("xor",     5'd2, 7'd0,       3'b100, 1'b0, 1'b1, 5'd5);
    chk_op("sltu",    5'd2, 7'd0,       3'b011, 1'b0, 1'b1, 5'd4);
    chk_op("addi_f7", 5'd3, 7'b0100000, 3'b000, 1'b0, 1'b1, 5'd0);
    chk_op("srai",    5'd3, 7'b0100000, 3'b101, 1'b0, 1'b1, 5'd7);
    chk_op("andi",    5'd3, 7'h55,      3'b111, 1'b0, 1'b1, 5'd9);
    chk_op("br_und",  5'd1, 7'd0,       3'b010, 1'b0, 1'b1, 5'd0);
    chk_op("r_und",   5'd2, 7'h7f,      3'b000, 1'b0, 1'b1, 5'd0);
    chk_op("op_und",  5'd7, 7'd0,       3'b000, 1'b0, 1'b1, 5'd0);
    chk_op("md_nost", 5'd2, 7'b0000001, 3'b000, 1'b0, 1'b0, 5'd18);
    idle();

    mop(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");

    // Reset in cycle 10 of a held DIVU; restart after rst falls
    @(posedge clk); #1;
    aluop = 5'd2; func7 = 7'b0000001; func3 = 3'b101;
    rs1 = 32'd1000; rs2 = 32'd10; start = 1'b1;
    t0 = cyc;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.push_back('{32'd100, cyc + 33, "div_rst"});
    @(negedge clk);
    check("rst_mid_result", md_result, 32'd0);
    check("rst_mid_done", {31'd0, md_done}, 32'd0);
    check("rst_mid_cyc", cyc - t0, 32'd11);
    wait_done("div_rst", 40, 1'b0);
    idle();

    mop(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    mop(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
    mop(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");

    issue(3'b000, 32'd6, 32'd7, 32'd42, 33, "mul_hold");
    wait_done("mul_hold", 38, 1'b1);
    idle();

    mop(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu");
    mop(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu");
    mop(3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33, "div");
    mop(3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33, "rem");
    mop(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, "divu_big");

    mop(3'b100, 32'h64, 32'd0, 32'hFFFFFFFF, 1, "div_z");
    mop(3'b110, 32'h64, 32'd0, 32'h64, 1, "rem_z");
    mop(3'b101, 32'h64, 32'd0, 32'hFFFFFFFF, 1, "divu_z");
    mop(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    mop(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf");

    issue(3'b000, 32'd3, 32'd5, 32'd15, 33, "b2b1");
    wait_done("b2b1", 38, 1'b0);
    issue(3'b000, 32'h00010001, 32'h00010000, 32'h00010000, 33, "b2b2");
    wait_done("b2b2", 38, 1'b0);
    idle();

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
